// File: rtl/if_fetch_if.sv
// Bundle of ROM, redirect/halt and IF/ID handshake signals around the fetch stage.
interface if_fetch_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [31:0] fetch_cnt_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o, fetch_cnt_o, flush_cnt_o,
    input  rom_inst_i, branch_flag_i, branch_target_i, halt_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o, fetch_cnt_o, flush_cnt_o,
    output rom_inst_i, branch_flag_i, branch_target_i, halt_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, combinational ROM access, small fetch queue, redirect and halt.
// Optional push/redirect counters are built when IF_FETCH_STATS_EN is defined.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PTR_W    = 1
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);
  localparam logic [PTR_W:0] CntFull = DEPTH[PTR_W:0];

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic             valid, pop, push, redirect;

  assign valid    = (count_q != '0);
  assign pop      = valid && bus.id_ready_i;
  assign redirect = bus.branch_flag_i && (state_q != StBoot);
  // A pop frees the slot this cycle, so a full queue can still accept a fetch.
  assign push     = (state_q == StRun) && !bus.branch_flag_i && ((count_q != CntFull) || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (bus.halt_i) state_d = StHalt;
      StHalt:  if (!bus.halt_i) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    if (redirect) begin
      count_d = '0;
      pc_d    = {bus.branch_target_i[31:2], 2'b00};
    end else begin
      if (push && !pop) count_d = count_q + (PTR_W+1)'(1);
      if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
      if (push)         pc_d    = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= bus.rom_inst_i;
    end
  end

  assign bus.rom_ce_o   = push;
  assign bus.rom_addr_o = push ? pc_q : '0;
  assign bus.if_valid_o = valid;
  assign bus.if_pc_o    = valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.if_inst_o  = valid ? inst_mem[rd_ptr_q] : '0;

`ifdef IF_FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.fetch_cnt_o = fetch_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.fetch_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: vector table plus hand sequences for async reset and counters.
module tb_if_fetch;
  logic clk;
  logic rst;
  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .PTR_W    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word[i] = 0x1000_0000 + i
  assign bus.rom_inst_i = 32'h1000_0000 + {2'b00, bus.rom_addr_o[31:2]};

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        hlt;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                     input logic hlt, input logic ce, input logic [31:0] addr, input logic vld,
                     input logic [31:0] pc);
    vec_t v;
    v.rst  = r;
    v.rdy  = rdy;
    v.br   = br;
    v.tgt  = tgt;
    v.hlt  = hlt;
    v.ce   = ce;
    v.addr = addr;
    v.vld  = vld;
    v.pc   = pc;
    v.inst = vld ? (32'h1000_0000 + (pc >> 2)) : 32'h0;
    vecs.push_back(v);
  endtask

  initial begin
    int          fcnt;
    int          xcnt;
    logic        prev_rst;
    logic [31:0] exp_f;
    logic [31:0] exp_x;

    rst                 = 1'b1;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = '0;
    bus.halt_i          = 1'b0;
    bus.id_ready_i      = 1'b0;

    //   rst rdy br tgt            hlt  ce addr           vld pc
    add(1, 1, 0, 0,             0,   0, 0,             0, 0);
    add(0, 1, 0, 0,             0,   0, 0,             0, 0);           // boot
    add(0, 1, 0, 0,             0,   1, 0,             0, 0);
    add(0, 1, 0, 0,             0,   1, 4,             1, 0);
    add(0, 1, 0, 0,             0,   1, 8,             1, 4);
    add(0, 1, 0, 0,             0,   1, 'hC,           1, 8);
    add(0, 0, 0, 0,             0,   1, 'h10,          1, 'hC);         // stall: fill
    add(0, 0, 0, 0,             0,   0, 0,             1, 'hC);
    add(0, 0, 0, 0,             0,   0, 0,             1, 'hC);
    add(0, 1, 0, 0,             0,   1, 'h14,          1, 'hC);         // push+pop at full
    add(0, 1, 0, 0,             0,   1, 'h18,          1, 'h10);
    add(0, 1, 1, 'h103,         0,   0, 0,             1, 'h14);        // redirect
    add(0, 1, 0, 0,             0,   1, 'h100,         0, 0);
    add(0, 1, 0, 0,             0,   1, 'h104,         1, 'h100);
    add(0, 0, 0, 0,             0,   1, 'h108,         1, 'h104);
    add(0, 1, 0, 0,             1,   1, 'h10C,         1, 'h104);       // halt seen at edge
    add(0, 1, 0, 0,             1,   0, 0,             1, 'h108);
    add(0, 1, 0, 0,             1,   0, 0,             1, 'h10C);
    add(0, 1, 0, 0,             1,   0, 0,             0, 0);
    add(0, 1, 0, 0,             0,   0, 0,             0, 0);
    add(0, 1, 0, 0,             0,   1, 'h110,         0, 0);
    add(0, 1, 0, 0,             0,   1, 'h114,         1, 'h110);
    add(0, 1, 1, 'h200,         1,   0, 0,             1, 'h114);       // redirect + halt
    add(0, 1, 0, 0,             1,   0, 0,             0, 0);
    add(0, 1, 0, 0,             0,   0, 0,             0, 0);
    add(0, 1, 0, 0,             0,   1, 'h200,         0, 0);
    add(0, 1, 0, 0,             0,   1, 'h204,         1, 'h200);
    add(0, 1, 1, 32'hFFFF_FFFF, 0,   0, 0,             1, 'h204);
    add(0, 1, 0, 0,             0,   1, 32'hFFFF_FFFC, 0, 0);
    add(0, 1, 0, 0,             0,   1, 0,             1, 32'hFFFF_FFFC); // pc wrap
    add(1, 1, 0, 0,             0,   0, 0,             0, 0);           // async reset
    add(0, 0, 0, 0,             0,   0, 0,             0, 0);
    add(0, 0, 0, 0,             0,   1, 0,             0, 0);
    add(0, 0, 0, 0,             0,   1, 4,             1, 0);
    add(0, 0, 0, 0,             0,   0, 0,             1, 0);
    add(0, 0, 0, 0,             0,   0, 0,             1, 0);
    add(0, 1, 0, 0,             0,   1, 8,             1, 0);
    add(0, 1, 0, 0,             0,   1, 'hC,           1, 4);
    add(0, 1, 0, 0,             0,   1, 'h10,          1, 8);
    add(1, 1, 0, 0,             0,   0, 0,             0, 0);
    add(0, 1, 1, 'h300,         0,   0, 0,             0, 0);           // redirect in boot
    add(0, 1, 0, 0,             0,   1, 0,             0, 0);
    add(0, 1, 0, 0,             0,   1, 4,             1, 0);

    repeat (2) @(posedge clk);
    #1;
    fcnt     = 0;
    xcnt     = 0;
    prev_rst = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      rst                 = vecs[k].rst;
      bus.id_ready_i      = vecs[k].rdy;
      bus.branch_flag_i   = vecs[k].br;
      bus.branch_target_i = vecs[k].tgt;
      bus.halt_i          = vecs[k].hlt;
      @(negedge clk);
      chk($sformatf("v%0d ce", k),    {31'b0, bus.rom_ce_o},   {31'b0, vecs[k].ce});
      chk($sformatf("v%0d addr", k),  bus.rom_addr_o,          vecs[k].addr);
      chk($sformatf("v%0d valid", k), {31'b0, bus.if_valid_o}, {31'b0, vecs[k].vld});
      chk($sformatf("v%0d pc", k),    bus.if_pc_o,             vecs[k].pc);
      chk($sformatf("v%0d inst", k),  bus.if_inst_o,           vecs[k].inst);
      if (vecs[k].rst) begin
        fcnt = 0;
        xcnt = 0;
      end
`ifdef IF_FETCH_STATS_EN
      exp_f = 32'(fcnt);
      exp_x = 32'(xcnt & 16'hFFFF);
`else
      exp_f = 32'h0;
      exp_x = 32'h0;
`endif
      chk($sformatf("v%0d fetch_cnt", k), bus.fetch_cnt_o,          exp_f);
      chk($sformatf("v%0d flush_cnt", k), {16'b0, bus.flush_cnt_o}, exp_x);
      if (!vecs[k].rst) begin
        if (vecs[k].ce) fcnt++;
        if (vecs[k].br && !prev_rst) xcnt++;
      end
      prev_rst = vecs[k].rst;
      @(posedge clk);
      #1;
    end

    // Async reset away from any edge: outputs must clear at once.
    bus.id_ready_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async ce",    {31'b0, bus.rom_ce_o},   32'h0);
    chk("async valid", {31'b0, bus.if_valid_o}, 32'h0);
    chk("async pc",    bus.if_pc_o,             32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    // 10 back-to-back fetches, then 2 redirects
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("seq%0d addr", i), bus.rom_addr_o, 32'(i * 4));
      if (i > 0) chk($sformatf("seq%0d pc", i), bus.if_pc_o, 32'((i - 1) * 4));
      @(posedge clk);
      #1;
    end
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h0000_0400;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("redir%0d ce", i), {31'b0, bus.rom_ce_o}, 32'h0);
      @(posedge clk);
      #1;
    end
    bus.branch_flag_i = 1'b0;
    @(negedge clk);
    chk("post redir addr", bus.rom_addr_o, 32'h0000_0400);
`ifdef IF_FETCH_STATS_EN
    exp_f = 32'd10;
    exp_x = 32'd2;
`else
    exp_f = 32'd0;
    exp_x = 32'd0;
`endif
    chk("stats fetch_cnt", bus.fetch_cnt_o,          exp_f);
    chk("stats flush_cnt", {16'b0, bus.flush_cnt_o}, exp_x);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and drives the ce/addr inputs of the combinational instruction ROM.
- Captures the returned instruction word, together with its PC, in the same cycle into a small fetch queue.
- Presents queue entries to the IF/ID boundary with a valid/ready handshake.
- Handles branch redirects (flush plus PC reload) and a halt request.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- DEPTH, 2, fetch-queue entries; power of two, 2..8.
- PTR_W, 1, log2(DEPTH).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_ce_o  output  1  ROM chip enable; 1 = fetch this cycle.
- rom_addr_o  output  32  byte address to ROM; always word aligned.
- rom_inst_i  input  32  instruction from ROM; valid combinationally in the same cycle as ce/addr.
- branch_flag_i  input  1  redirect request from EX.
- branch_target_i  input  32  redirect address.
- halt_i  input  1  level; 1 = stop issuing new fetches.
- id_ready_i  input  1  ID accepts the head entry this cycle.
- if_valid_o  output  1  head entry valid.
- if_pc_o  output  32  PC of head entry.
- if_inst_o  output  32  instruction of head entry.
- fetch_cnt_o  output  32  fetches committed to the queue (see Optional Feature).
- flush_cnt_o  output  16  redirects taken (see Optional Feature).

Behaviour:
- Reset (async assert): pc=RESET_PC, queue empty, state=S_BOOT.
  - Outputs during reset: rom_ce_o=0, rom_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0, counters=0.
- States:
  - S_BOOT: one cycle, no fetch; then goes to S_RUN.
  - S_RUN: issues fetches. halt_i=1 moves to S_HALT.
  - S_HALT: no fetch; the queue keeps draining to ID. halt_i=0 returns to S_RUN.
  - Redirect is legal in any state except S_BOOT, where it is ignored. Redirect does not change state.
- Fetch condition: state==S_RUN, branch_flag_i=0, and (count<DEPTH or pop this cycle).
  - When the condition holds: rom_ce_o=1, rom_addr_o=pc, and rom_inst_i with pc is written at the tail at the clock edge. pc<=pc+4.
  - When it does not hold: rom_ce_o=0, rom_addr_o=0, and pc holds.
- Pop: if_valid_o && id_ready_i removes the head at the edge.
  - Simultaneous push+pop at full is allowed; count is unchanged.
- Outputs if_valid_o/if_pc_o/if_inst_o are the head entry directly from registers.
  - When the queue is empty: if_valid_o=0, if_pc_o=0, if_inst_o=0.
- Redirect (branch_flag_i=1, not S_BOOT):
  - At the edge: all queue entries are discarded, including the current head even if popped; count=0.
  - pc <= {branch_target_i[31:2],2'b00}.
  - No fetch that cycle (rom_ce_o=0).
  - The first fetch from the target is issued the next cycle if in S_RUN.
- Redirect together with halt_i: both take effect; pc is reloaded and the state moves to S_HALT.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never overflows or underflows.
- Steady-state latency: a PC presented to the ROM is visible on if_pc_o the next cycle if the queue was empty.
- After S_BOOT, throughput is 1 instruction/cycle with id_ready_i held at 1.

Optional Feature:
- Macro: IF_FETCH_STATS_EN.
- Defined:
  - fetch_cnt_o increments by 1 on every queue push.
  - flush_cnt_o increments by 1 on every accepted redirect.
  - Both counters wrap silently and are cleared by rst.
- Undefined: counter logic is absent; fetch_cnt_o=0 and flush_cnt_o=0 constant. Ports remain for a stable interface.

Test Plan:
- Reset release, id_ready_i=1, ROM word[i]=32'h1000_0000+i.
  - Cycle 1: ce=0.
  - From cycle 2: rom_addr_o=0,4,8,...
  - From cycle 3: if_pc_o/if_inst_o are (0,32'h1000_0000), (4,32'h1000_0001), ..., one per cycle.
- id_ready_i=0 from reset.
  - Queue fills with pc 0,4 and rom_ce_o drops to 0.
  - if_pc_o holds 0.
  - Raising ready yields 0,4,8 with no gap or duplicate.
- Redirect while the queue holds pc 8,12: branch_flag_i=1, target=32'h0000_0103.
  - Next cycle: if_valid_o=0 and rom_addr_o=32'h100.
  - One cycle later: if_pc_o=32'h100.
- halt_i=1 with 2 entries queued and ready=1.
  - Both entries drain.
  - rom_ce_o stays 0 until halt_i=0, after which fetch resumes at the next sequential pc.
- Reset asserted asynchronously mid-stream (not on a clock edge).
  - Outputs go to 0 immediately.
  - After release, the fetch sequence restarts at RESET_PC.
- With IF_FETCH_STATS_EN: 10 fetches plus 2 redirects give fetch_cnt_o=10, flush_cnt_o=2.
  - Without the macro, both read 0.
